// File: rtl/uart_pkg.sv
// Shared definitions for the UART bus bridge: register map, STATUS bit
// positions, FSM state encodings and the STATUS packing helper.
package uart_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned REG_W    = 3;

    // STATUS bit positions
    localparam int unsigned ST_EMPTY = 0;
    localparam int unsigned ST_FULL  = 1;
    localparam int unsigned ST_BUSY  = 2;
    localparam int unsigned ST_TXOVF = 3;
    localparam int unsigned ST_RXUDF = 4;

    typedef enum logic [REG_W-1:0] {
        REG_CTRL1  = 3'd0,
        REG_CTRL2  = 3'd1,
        REG_CTRL3  = 3'd2,
        REG_APPLY  = 3'd3,
        REG_TXDATA = 3'd4,
        REG_RXDATA = 3'd5,
        REG_STATUS = 3'd6,
        REG_CLEAR  = 3'd7
    } reg_addr_e;

    // Bus-side transaction FSM
    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_ACK  = 2'd1,
        BUS_RX   = 2'd2
    } bus_state_e;

    // RX FIFO read sequencer FSM
    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        RX_STROBE  = 2'd1,
        RX_WAIT    = 2'd2,
        RX_CAPTURE = 2'd3
    } rx_state_e;

    typedef struct packed {
        logic rx_udf;
        logic tx_ovf;
    } sticky_flags_t;

    function automatic logic [DATA_W-1:0] status_byte(
        input sticky_flags_t flags,
        input logic          busy,
        input logic          full,
        input logic          empty
    );
        logic [DATA_W-1:0] s;
        s           = '0;
        s[ST_RXUDF] = flags.rx_udf;
        s[ST_TXOVF] = flags.tx_ovf;
        s[ST_BUSY]  = busy;
        s[ST_FULL]  = full;
        s[ST_EMPTY] = empty;
        return s;
    endfunction

endpackage

// File: rtl/uart_bus_bridge_if.sv
// Register bus between a host (master) and the bridge (slave).
// bus_addr_i/bus_we_i/bus_re_i/bus_wdata_i: request; bus_rdata_o/bus_ack_o/bus_rdy_o: response.
interface uart_bus_bridge_if #(
    parameter int unsigned ADDR_W = 3
) ();
    logic [ADDR_W-1:0] bus_addr_i;
    logic              bus_we_i;
    logic              bus_re_i;
    logic [7:0]        bus_wdata_i;
    logic [7:0]        bus_rdata_o;
    logic              bus_ack_o;
    logic              bus_rdy_o;

    modport master (
        output bus_addr_i, bus_we_i, bus_re_i, bus_wdata_i,
        input  bus_rdata_o, bus_ack_o, bus_rdy_o
    );

    modport slave (
        input  bus_addr_i, bus_we_i, bus_re_i, bus_wdata_i,
        output bus_rdata_o, bus_ack_o, bus_rdy_o
    );
endinterface

// File: rtl/uart_rx_read_seq.sv
// RX FIFO read sequencer: one-cycle active-low read strobe, RD_LATENCY-1 wait
// cycles, then a one-cycle capture window in which rx data is valid.
// Ports: clk, rst (sync, active-high), start_i (launch), n_rd_o (strobe),
//        capture_o (high during the cycle rx data must be latched).
module uart_rx_read_seq
    import uart_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    output logic n_rd_o,
    output logic capture_o
);

    localparam int unsigned CNT_W     = 2;
    localparam int unsigned WAIT_LOAD = (RD_LATENCY > 1) ? RD_LATENCY - 2 : 0;

    rx_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               n_rd_q, n_rd_d;
    logic               capture_q, capture_d;

    // Next-state and registered-output decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            RX_IDLE: begin
                if (start_i) state_d = RX_STROBE;
            end
            RX_STROBE: begin
                if (RD_LATENCY > 1) begin
                    state_d = RX_WAIT;
                    cnt_d   = CNT_W'(WAIT_LOAD);
                end else begin
                    state_d = RX_CAPTURE;
                end
            end
            RX_WAIT: begin
                if (cnt_q == '0) state_d = RX_CAPTURE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            RX_CAPTURE: begin
                state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
        // outputs follow the state being entered so they line up with it
        n_rd_d    = (state_d != RX_STROBE);
        capture_d = (state_d == RX_CAPTURE);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            n_rd_q    <= 1'b1;
            capture_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            n_rd_q    <= n_rd_d;
            capture_q <= capture_d;
        end
    end

    assign n_rd_o    = n_rd_q;
    assign capture_o = capture_q;

endmodule

// File: rtl/uart_bus_bridge.sv
// Register-bus to UART FIFO bridge: control registers, apply pulse, TX FIFO
// write, RX FIFO read with configurable latency, sticky status flags.
// Ports: clk, rst (sync, active-high); bus (register bus slave);
//        p_We_o, CtrlReg1_o..CtrlReg3_o (control); tx_data_o, n_we_o, p_full_i (TX FIFO);
//        rx_data_i, n_rd_o, p_empty_i (RX FIFO); n_clr_o (FIFO clear).
module uart_bus_bridge
    import uart_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned ADDR_W     = 3
) (
    input  logic                clk,
    input  logic                rst,
    uart_bus_bridge_if.slave    bus,
    output logic                p_We_o,
    output logic [DATA_W-1:0]   CtrlReg1_o,
    output logic [DATA_W-1:0]   CtrlReg2_o,
    output logic [DATA_W-1:0]   CtrlReg3_o,
    output logic [DATA_W-1:0]   tx_data_o,
    output logic                n_we_o,
    input  logic                p_full_i,
    input  logic [DATA_W-1:0]   rx_data_i,
    output logic                n_rd_o,
    input  logic                p_empty_i,
    output logic                n_clr_o
);

    bus_state_e         state_q, state_d;
    logic [DATA_W-1:0]  ctrl1_q, ctrl1_d;
    logic [DATA_W-1:0]  ctrl2_q, ctrl2_d;
    logic [DATA_W-1:0]  ctrl3_q, ctrl3_d;
    logic [DATA_W-1:0]  txd_q, txd_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               pwe_q, pwe_d;
    logic               nwe_q, nwe_d;
    logic               nclr_q, nclr_d;
    logic               ack_q, ack_d;
    logic               rdy_q, rdy_d;
    sticky_flags_t      flags_q, flags_d;

    logic [ADDR_W-1:0]  addr_c;
    logic               addr_hit_c;
    reg_addr_e          reg_sel_c;
    logic               wr_acc_c, rd_acc_c;
    logic               busy_c;
    logic [DATA_W-1:0]  rd_val_c;
    logic               seq_start_c;
    logic               seq_capture;
    logic               set_ovf_c, set_udf_c, clr_flags_c;

    // Address decode; anything above the 8-entry map is unmapped
    assign addr_c     = ADDR_W'(bus.bus_addr_i);
    assign addr_hit_c = ((addr_c >> REG_W) == '0);
    assign reg_sel_c  = reg_addr_e'(REG_W'(addr_c));

    // Write wins over a simultaneous read
    assign wr_acc_c = rdy_q & bus.bus_we_i;
    assign rd_acc_c = rdy_q & bus.bus_re_i & ~bus.bus_we_i;
    assign busy_c   = (state_q != BUS_IDLE);

    // Read mux for single-cycle reads; write-only and unmapped return zero
    always_comb begin
        rd_val_c = '0;
        if (addr_hit_c) begin
            unique case (reg_sel_c)
                REG_CTRL1:  rd_val_c = ctrl1_q;
                REG_CTRL2:  rd_val_c = ctrl2_q;
                REG_CTRL3:  rd_val_c = ctrl3_q;
                REG_STATUS: rd_val_c = status_byte(flags_q, busy_c, p_full_i, p_empty_i);
                default:    rd_val_c = '0;
            endcase
        end
    end

    // Transaction FSM next-state and registered-output decode
    always_comb begin
        state_d     = state_q;
        ctrl1_d     = ctrl1_q;
        ctrl2_d     = ctrl2_q;
        ctrl3_d     = ctrl3_q;
        txd_d       = txd_q;
        rdata_d     = rdata_q;
        pwe_d       = 1'b0;
        nwe_d       = 1'b1;
        nclr_d      = 1'b1;
        ack_d       = 1'b0;
        seq_start_c = 1'b0;
        set_ovf_c   = 1'b0;
        set_udf_c   = 1'b0;
        clr_flags_c = 1'b0;

        unique case (state_q)
            BUS_IDLE: begin
                if (wr_acc_c) begin
                    state_d = BUS_ACK;
                    ack_d   = 1'b1;
                    if (addr_hit_c) begin
                        unique case (reg_sel_c)
                            REG_CTRL1:  ctrl1_d = bus.bus_wdata_i;
                            REG_CTRL2:  ctrl2_d = bus.bus_wdata_i;
                            REG_CTRL3:  ctrl3_d = bus.bus_wdata_i;
                            REG_APPLY:  pwe_d   = 1'b1;
                            REG_TXDATA: begin
                                if (p_full_i) begin
                                    set_ovf_c = 1'b1;
                                end else begin
                                    txd_d = bus.bus_wdata_i;
                                    nwe_d = 1'b0;
                                end
                            end
                            REG_CLEAR: begin
                                nclr_d      = ~bus.bus_wdata_i[0];
                                clr_flags_c = bus.bus_wdata_i[1];
                            end
                            default: ;
                        endcase
                    end
                end else if (rd_acc_c) begin
                    if (addr_hit_c && (reg_sel_c == REG_RXDATA) && !p_empty_i) begin
                        state_d     = BUS_RX;
                        seq_start_c = 1'b1;
                    end else begin
                        state_d = BUS_ACK;
                        ack_d   = 1'b1;
                        rdata_d = rd_val_c;
                        set_udf_c = addr_hit_c && (reg_sel_c == REG_RXDATA);
                    end
                end
            end
            BUS_ACK: begin
                state_d = BUS_IDLE;
            end
            BUS_RX: begin
                if (seq_capture) begin
                    state_d = BUS_ACK;
                    ack_d   = 1'b1;
                    rdata_d = rx_data_i;
                end
            end
            default: state_d = BUS_IDLE;
        endcase

        // Clear beats a same-cycle set
        flags_d.tx_ovf = (flags_q.tx_ovf | set_ovf_c) & ~clr_flags_c;
        flags_d.rx_udf = (flags_q.rx_udf | set_udf_c) & ~clr_flags_c;
        rdy_d          = (state_d == BUS_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BUS_IDLE;
            ctrl1_q <= '0;
            ctrl2_q <= '0;
            ctrl3_q <= '0;
            txd_q   <= '0;
            rdata_q <= '0;
            pwe_q   <= 1'b0;
            nwe_q   <= 1'b1;
            nclr_q  <= 1'b1;
            ack_q   <= 1'b0;
            rdy_q   <= 1'b1;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl1_q <= ctrl1_d;
            ctrl2_q <= ctrl2_d;
            ctrl3_q <= ctrl3_d;
            txd_q   <= txd_d;
            rdata_q <= rdata_d;
            pwe_q   <= pwe_d;
            nwe_q   <= nwe_d;
            nclr_q  <= nclr_d;
            ack_q   <= ack_d;
            rdy_q   <= rdy_d;
            flags_q <= flags_d;
        end
    end

    uart_rx_read_seq #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rx_seq (
        .clk       (clk),
        .rst       (rst),
        .start_i   (seq_start_c),
        .n_rd_o    (n_rd_o),
        .capture_o (seq_capture)
    );

    assign bus.bus_rdata_o = rdata_q;
    assign bus.bus_ack_o   = ack_q;
    assign bus.bus_rdy_o   = rdy_q;
    assign p_We_o          = pwe_q;
    assign CtrlReg1_o      = ctrl1_q;
    assign CtrlReg2_o      = ctrl2_q;
    assign CtrlReg3_o      = ctrl3_q;
    assign tx_data_o       = txd_q;
    assign n_we_o          = nwe_q;
    assign n_clr_o         = nclr_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Bench for uart_bus_bridge: directed steps plus a randomized transaction run
// on a RD_LATENCY=1 instance, and RX-latency/abort steps on a RD_LATENCY=3 one.
module tb_uart_bus_bridge;
    import uart_pkg::*;

    localparam int unsigned L1 = 1;
    localparam int unsigned L3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1, rst3;
    uart_bus_bridge_if #(.ADDR_W(3)) bus1 ();
    uart_bus_bridge_if #(.ADDR_W(3)) bus3 ();

    logic       pwe1, nwe1, nrd1, nclr1, full1, empty1;
    logic [7:0] ca1, cb1, cc1, txd1, rxd1;
    logic       pwe3, nwe3, nrd3, nclr3, full3, empty3;
    logic [7:0] ca3, cb3, cc3, txd3, rxd3;

    uart_bus_bridge #(.RD_LATENCY(L1), .ADDR_W(3)) dut1 (
        .clk(clk), .rst(rst1), .bus(bus1), .p_We_o(pwe1),
        .CtrlReg1_o(ca1), .CtrlReg2_o(cb1), .CtrlReg3_o(cc1),
        .tx_data_o(txd1), .n_we_o(nwe1), .p_full_i(full1),
        .rx_data_i(rxd1), .n_rd_o(nrd1), .p_empty_i(empty1), .n_clr_o(nclr1)
    );

    uart_bus_bridge #(.RD_LATENCY(L3), .ADDR_W(3)) dut3 (
        .clk(clk), .rst(rst3), .bus(bus3), .p_We_o(pwe3),
        .CtrlReg1_o(ca3), .CtrlReg2_o(cb3), .CtrlReg3_o(cc3),
        .tx_data_o(txd3), .n_we_o(nwe3), .p_full_i(full3),
        .rx_data_i(rxd3), .n_rd_o(nrd3), .p_empty_i(empty3), .n_clr_o(nclr3)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // RX FIFO model: data valid exactly L cycles after the strobe cycle, garbage otherwise
    logic [3:0] hist1 = '0, hist3 = '0;
    logic [7:0] rxv1 = 8'h00, rxv3 = 8'h00;
    always @(negedge clk) begin
        hist1 = {hist1[2:0], ~nrd1};
        hist3 = {hist3[2:0], ~nrd3};
        rxd1  = hist1[L1] ? rxv1 : ~rxv1;
        rxd3  = hist3[L3] ? rxv3 : ~rxv3;
    end

    // Observation results of one access window
    int         r_first_ack, r_acks, r_nwe, r_nrd, r_pwe, r_nclr, r_overlap;
    logic [7:0] r_rdata, r_txd;
    logic       r_rdy_at_ack;
    logic       s_ack, s_rdy, s_nwe, s_nrd, s_nclr, s_pwe;
    logic [7:0] s_rd, s_txd;

    task automatic drive(input int d, input logic we, input logic re,
                         input logic [2:0] a, input logic [7:0] wd);
        if (d == 1) begin
            bus1.bus_we_i = we; bus1.bus_re_i = re; bus1.bus_addr_i = a; bus1.bus_wdata_i = wd;
        end else begin
            bus3.bus_we_i = we; bus3.bus_re_i = re; bus3.bus_addr_i = a; bus3.bus_wdata_i = wd;
        end
    endtask

    // inject: 0 none, 1 extra write strobe while busy, 2 reset pulse in cycle 2
    task automatic access(input int d, input logic we, input logic re, input logic [2:0] a,
                          input logic [7:0] wd, input int inject);
        @(negedge clk);
        drive(d, we, re, a, wd);
        @(posedge clk);
        #1 drive(d, 1'b0, 1'b0, a, wd);
        r_first_ack = 0; r_acks = 0; r_nwe = 0; r_nrd = 0; r_pwe = 0; r_nclr = 0;
        r_overlap = 0; r_rdata = 8'h00; r_txd = 8'h00; r_rdy_at_ack = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (d == 1) begin
                s_ack = bus1.bus_ack_o; s_rdy = bus1.bus_rdy_o; s_rd = bus1.bus_rdata_o;
                s_nwe = nwe1; s_nrd = nrd1; s_nclr = nclr1; s_pwe = pwe1; s_txd = txd1;
            end else begin
                s_ack = bus3.bus_ack_o; s_rdy = bus3.bus_rdy_o; s_rd = bus3.bus_rdata_o;
                s_nwe = nwe3; s_nrd = nrd3; s_nclr = nclr3; s_pwe = pwe3; s_txd = txd3;
            end
            if (s_ack === 1'b1) begin
                r_acks++;
                if (r_first_ack == 0) begin
                    r_first_ack = n; r_rdata = s_rd; r_rdy_at_ack = s_rdy;
                end
            end
            if ((int'(!s_nwe) + int'(!s_nrd) + int'(!s_nclr)) > 1) r_overlap++;
            if (s_nwe === 1'b0) begin r_nwe++; r_txd = s_txd; end
            if (s_nrd === 1'b0) r_nrd++;
            if (s_nclr === 1'b0) r_nclr++;
            if (s_pwe === 1'b1) r_pwe++;
            if (inject == 1 && n == 1) drive(d, 1'b1, 1'b1, 3'd0, 8'hFF);
            if (inject == 1 && n == 2) drive(d, 1'b0, 1'b0, 3'd0, 8'h00);
            if (inject == 2 && n == 2) begin if (d == 1) rst1 = 1'b1; else rst3 = 1'b1; end
            if (inject == 2 && n == 3) begin if (d == 1) rst1 = 1'b0; else rst3 = 1'b0; end
        end
    endtask

    // Reference model of the RD_LATENCY=1 instance
    logic [7:0] m_ctrl [3];
    logic [7:0] m_txd, m_last;
    bit         m_ovf, m_udf;

    task automatic run_op1(input string tag, input logic we, input logic re, input logic [2:0] a,
                           input logic [7:0] wd, input logic full, input logic empty,
                           input logic [7:0] rxv);
        int         e_lat, e_nwe, e_nrd, e_pwe, e_nclr;
        logic [7:0] e_rd;
        full1 = full; empty1 = empty; rxv1 = rxv;
        e_lat = 0; e_nwe = 0; e_nrd = 0; e_pwe = 0; e_nclr = 0; e_rd = m_last;
        if (we) begin
            e_lat = 1;
            if (a <= 3'd2) m_ctrl[a] = wd;
            else if (a == 3'd3) e_pwe = 1;
            else if (a == 3'd4) begin
                if (!full) begin e_nwe = 1; m_txd = wd; end
                else m_ovf = 1;
            end else if (a == 3'd7) begin
                if (wd[0]) e_nclr = 1;
                if (wd[1]) begin m_ovf = 0; m_udf = 0; end
            end
        end else if (re) begin
            e_lat = 1;
            if (a <= 3'd2) e_rd = m_ctrl[a];
            else if (a == 3'd5) begin
                if (empty) begin e_rd = 8'h00; m_udf = 1; end
                else begin e_rd = rxv; e_lat = L1 + 2; e_nrd = 1; end
            end else if (a == 3'd6)
                e_rd = 8'((m_udf ? 16 : 0) + (m_ovf ? 8 : 0) + (full ? 2 : 0) + (empty ? 1 : 0));
            else e_rd = 8'h00;
            m_last = e_rd;
        end
        access(1, we, re, a, wd, 0);
        chk({tag, ".ack_cycle"}, r_first_ack, e_lat);
        chk({tag, ".ack_count"}, r_acks, (e_lat != 0) ? 1 : 0);
        if (e_lat != 0) begin
            chk({tag, ".rdata"}, r_rdata, e_rd);
            chk({tag, ".rdy_at_ack"}, r_rdy_at_ack, 0);
        end
        chk({tag, ".n_we_pulses"}, r_nwe, e_nwe);
        if (e_nwe != 0) chk({tag, ".tx_data"}, r_txd, m_txd);
        chk({tag, ".n_rd_pulses"}, r_nrd, e_nrd);
        chk({tag, ".p_we_pulses"}, r_pwe, e_pwe);
        chk({tag, ".n_clr_pulses"}, r_nclr, e_nclr);
        chk({tag, ".strobe_overlap"}, r_overlap, 0);
        chk({tag, ".ctrl1"}, ca1, m_ctrl[0]);
        chk({tag, ".ctrl2"}, cb1, m_ctrl[1]);
        chk({tag, ".ctrl3"}, cc1, m_ctrl[2]);
        chk({tag, ".rdata_hold"}, bus1.bus_rdata_o, m_last);
        chk({tag, ".rdy_idle"}, bus1.bus_rdy_o, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        int         kind;
        logic [2:0] a;
        rst1 = 1'b1; rst3 = 1'b1;
        full1 = 1'b0; empty1 = 1'b1; full3 = 1'b0; empty3 = 1'b1;
        drive(1, 1'b0, 1'b0, 3'd0, 8'h00);
        drive(3, 1'b0, 1'b0, 3'd0, 8'h00);
        for (int i = 0; i < 3; i++) m_ctrl[i] = 8'h00;
        m_txd = 8'h00; m_last = 8'h00; m_ovf = 0; m_udf = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.ctrl1", ca1, 8'h00);
        chk("rst.ctrl2", cb1, 8'h00);
        chk("rst.ctrl3", cc1, 8'h00);
        chk("rst.p_we", pwe1, 1'b0);
        chk("rst.n_we", nwe1, 1'b1);
        chk("rst.n_rd", nrd1, 1'b1);
        chk("rst.n_clr", nclr1, 1'b1);
        chk("rst.tx_data", txd1, 8'h00);
        chk("rst.rdata", bus1.bus_rdata_o, 8'h00);
        chk("rst.ack", bus1.bus_ack_o, 1'b0);
        chk("rst.rdy", bus1.bus_rdy_o, 1'b1);
        chk("rst.rdy3", bus3.bus_rdy_o, 1'b1);
        rst1 = 1'b0; rst3 = 1'b0;

        // control register write, apply, readback
        run_op1("ctrl1_wr", 1, 0, 3'd0, 8'hA5, 0, 1, 8'h00);
        run_op1("apply",    1, 0, 3'd3, 8'h00, 0, 1, 8'h00);
        run_op1("ctrl1_rd", 0, 1, 3'd0, 8'h00, 0, 1, 8'h00);
        chk("ctrl1_rd.const", r_rdata, 8'hA5);

        // TX write, then overflow
        run_op1("tx_ok",   1, 0, 3'd4, 8'h3C, 0, 1, 8'h00);
        chk("tx_ok.const", r_txd, 8'h3C);
        run_op1("tx_full", 1, 0, 3'd4, 8'h77, 1, 1, 8'h00);
        run_op1("stat_ovf", 0, 1, 3'd6, 8'h00, 0, 1, 8'h00);
        chk("stat_ovf.const", r_rdata, 8'h09);

        // RX read with data, then underflow, then clear
        run_op1("rx_ok", 0, 1, 3'd5, 8'h00, 0, 0, 8'h5A);
        chk("rx_ok.const", r_rdata, 8'h5A);
        run_op1("rx_udf",    0, 1, 3'd5, 8'h00, 0, 1, 8'h33);
        run_op1("stat_udf",  0, 1, 3'd6, 8'h00, 0, 1, 8'h00);
        chk("stat_udf.const", r_rdata, 8'h19);
        run_op1("clr_flags", 1, 0, 3'd7, 8'h02, 0, 1, 8'h00);
        run_op1("stat_clr",  0, 1, 3'd6, 8'h00, 0, 1, 8'h00);
        chk("stat_clr.const", r_rdata, 8'h01);
        run_op1("clr_fifo",  1, 0, 3'd7, 8'h01, 0, 1, 8'h00);
        run_op1("wr_rd_both", 1, 1, 3'd1, 8'hC3, 0, 1, 8'h00);
        run_op1("wo_read",   0, 1, 3'd3, 8'h00, 0, 1, 8'h00);

        // randomized transactions against the model
        for (int k = 0; k < 40; k++) begin
            kind = int'($urandom_range(0, 5));
            a    = 3'($urandom_range(0, 7));
            v    = 8'($urandom);
            run_op1("rand", (kind == 0 || kind == 1 || kind == 4), (kind == 2 || kind == 3 || kind == 4),
                    a, v, 1'($urandom), 1'($urandom), 8'($urandom));
        end

        // RD_LATENCY=3: ack at cycle 5, a strobe while busy is ignored
        full3 = 1'b0; empty3 = 1'b0; rxv3 = 8'($urandom);
        access(3, 1'b0, 1'b1, 3'd5, 8'h00, 1);
        chk("lat3.ack_cycle", r_first_ack, L3 + 2);
        chk("lat3.ack_count", r_acks, 1);
        chk("lat3.rdata", r_rdata, rxv3);
        chk("lat3.n_rd_pulses", r_nrd, 1);
        chk("lat3.ignored_wr", ca3, 8'h00);

        // reset during the wait phase aborts the read
        rxv3 = 8'($urandom);
        access(3, 1'b0, 1'b1, 3'd5, 8'h00, 2);
        chk("abort.ack_count", r_acks, 0);
        chk("abort.n_rd_pulses", r_nrd, 1);
        chk("abort.n_rd", nrd3, 1'b1);
        chk("abort.rdy", bus3.bus_rdy_o, 1'b1);
        chk("abort.rdata", bus3.bus_rdata_o, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_bus_bridge.md
UART_BUS_BRIDGE -- requirements
Module: uart_bus_bridge

Interface
REQ-001 Parameter RD_LATENCY, default 1: cycles from n_rd_o low to valid rx_data_i (range 1..3).
REQ-002 Parameter ADDR_W, default 3: bus address width.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 bus_addr_i  in  ADDR_W  register address; bus_we_i  in  1  one-cycle write strobe; bus_re_i  in  1  one-cycle read strobe.
REQ-006 bus_wdata_i  in  8  write data; bus_rdata_o  out  8  read data; bus_ack_o  out  1  one-cycle completion pulse; bus_rdy_o  out  1  bridge idle, accepting requests.
REQ-007 p_We_o  out  1  control-apply pulse; CtrlReg1_o/CtrlReg2_o/CtrlReg3_o  out  8 each  control register contents.
REQ-008 tx_data_o  out  8  tx FIFO write data; n_we_o  out  1  active-low tx FIFO write strobe; p_full_i  in  1  tx FIFO full.
REQ-009 rx_data_i  in  8  rx FIFO data; n_rd_o  out  1  active-low rx FIFO read strobe; p_empty_i  in  1  rx FIFO empty.
REQ-010 n_clr_o  out  1  active-low FIFO clear pulse.

Function
REQ-011 Register map: 0 CTRL1 RW; 1 CTRL2 RW; 2 CTRL3 RW; 3 APPLY W; 4 TXDATA W; 5 RXDATA R; 6 STATUS R; 7 CLEAR W.
REQ-012 Request accepted only when bus_rdy_o=1; strobes while bus_rdy_o=0 ignored, no ack; bus_we_i and bus_re_i both high: write wins, read dropped.
REQ-013 Simple accesses (all except RXDATA read): ack exactly 1 cycle after acceptance; bus_rdy_o low during that cycle.
REQ-014 Write CTRLn: register updated at acceptance edge; reads return current value; write-only addresses read 0x00.
REQ-015 Write APPLY: p_We_o high exactly 1 cycle, the cycle after acceptance; data ignored.
REQ-016 Write TXDATA, p_full_i=0 at acceptance: tx_data_o=wdata, n_we_o low exactly 1 cycle after acceptance; p_full_i=1: no strobe, STATUS.tx_ovf set, ack still given.
REQ-017 Write CLEAR: bit0=1 -> n_clr_o low 1 cycle; bit1=1 -> clear tx_ovf and rx_udf; bit1 clear has priority over same-cycle set.
REQ-018 Read RXDATA, p_empty_i=0: FSM IDLE -> STROBE (n_rd_o low 1 cycle) -> WAIT (RD_LATENCY-1 cycles) -> CAPTURE (latch rx_data_i) -> ACK; total ack latency RD_LATENCY+2 cycles after acceptance.
REQ-019 Read RXDATA, p_empty_i=1 at acceptance: no n_rd_o, rdata=0x00, rx_udf set, ack after 1 cycle.
REQ-020 STATUS = {3'b0, rx_udf, tx_ovf, busy, p_full_i, p_empty_i}; busy = FSM not IDLE at sample.
REQ-021 bus_rdata_o holds last read value until next read ack; valid only when bus_ack_o=1.
REQ-022 n_we_o, n_rd_o, n_clr_o never low in the same cycle; each strobe is a single cycle, high otherwise.

Reset
REQ-023 On rst: FSM IDLE, CtrlReg1/2/3_o=0x00, p_We_o=0, n_we_o=1, n_rd_o=1, n_clr_o=1, tx_data_o=0x00, bus_rdata_o=0x00, bus_ack_o=0, bus_rdy_o=1, sticky flags 0.
REQ-024 rst mid-transaction aborts it: no ack, strobes return high next cycle, outstanding capture discarded.
REQ-025 Post-reset CtrlReg values not applied until an explicit APPLY write.

Structure
REQ-026 Register addresses, STATUS bit positions and FSM state encoding in shared package uart_pkg.
REQ-027 Single module; rx read sequencer may be sub-module uart_rx_read_seq.

Verification
REQ-028 Reset then write CTRL1=0xA5, APPLY -> CTRL1 reads 0xA5, p_We_o one pulse, 1-cycle ack each.
REQ-029 TXDATA write 0x3C, p_full_i=0 -> n_we_o low 1 cycle with tx_data_o=0x3C; repeat with p_full_i=1 -> no strobe, STATUS=0x09 (tx_ovf set, empty high).
REQ-030 RXDATA read, p_empty_i=0, rx_data_i=0x5A valid RD_LATENCY after strobe -> ack at cycle 3, rdata 0x5A; RD_LATENCY=3 -> ack at cycle 5.
REQ-031 RXDATA read, p_empty_i=1 -> rdata 0x00, no n_rd_o, rx_udf set; CLEAR 0x02 -> STATUS flags 0.
REQ-032 New strobe during RXDATA sequence -> ignored, single ack; rst asserted in WAIT -> no ack, n_rd_o high, bus_rdy_o=1.
